chr_mem_arbiter: RTL and testbench
==================================

Name: chr_mem_arbiter

Overview:
- Shares the single-port 8 KB CHR block RAM between two requesters.
- PPU pattern-fetch bridge: read-only, latency-critical, high priority.
- SDRAM-to-CHR loader: read/write, fills the RAM at init, low priority with a starvation guard.
- Owns the chr_ready flag that gates PPU reads until the loader has finished filling the RAM.

Parameters:
- ADDR_W, 13, CHR RAM address width (8 KB).
- DATA_W, 8, data width.
- RD_LAT, 1, block RAM read latency in cycles (1..3).
- MAX_WAIT, 4, consecutive PPU grants allowed while the loader is pending before the loader is forced a grant (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ppu_req  in  1  PPU read request; level, held until ppu_ack
- ppu_addr  in  ADDR_W  PPU read address
- ppu_ack  out  1  one-cycle pulse; ppu_rdata valid in the same cycle
- ppu_rdata  out  DATA_W  PPU read data, held until the next PPU ack
- ld_req  in  1  loader request; level, held until ld_ack
- ld_we  in  1  1 = write, 0 = read
- ld_last  in  1  qualifies a write as the final fill write
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle pulse
- ld_rdata  out  DATA_W  loader read data, valid with ld_ack
- mem_addr  out  ADDR_W  block RAM address (registered)
- mem_we  out  1  block RAM write enable (registered)
- mem_din  out  DATA_W  block RAM write data (registered)
- mem_dout  in  DATA_W  block RAM read data, RD_LAT cycles after the address edge
- chr_ready  out  1  1 = RAM filled, PPU reads served from memory

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: every output is 0, including ppu_rdata and ld_rdata (0x00) and chr_ready. FSM goes to IDLE and the starvation counter clears.
- Reset mid-transaction aborts it: no ack is issued and mem_we drops on the next cycle.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE arbitration, in order:
  - ld_req with wait_cnt == MAX_WAIT → loader.
  - Otherwise ppu_req → PPU.
  - Otherwise ld_req → loader.
  - The winner's address, we and wdata are registered onto mem_*; go to ISSUE.
- PPU request while chr_ready == 0: no memory access. Go straight to ACK with ppu_rdata = 0x00 (PPU latency 1 cycle, request edge to ack).
- ISSUE:
  - mem_* is presented for exactly one cycle; mem_we is high only for a loader write.
  - Write → ACK.
  - Read → WAIT.
- WAIT: counts RD_LAT cycles. On the last count, captures mem_dout into the winner's rdata register and goes to ACK.
- ACK:
  - Winner's ack is high for exactly one cycle, then IDLE. The requester must drop or change req at the edge ending the ack cycle.
  - IDLE re-arbitrates the cycle after ACK, so there is one bubble per transaction.
- Latency, sampled-in-IDLE edge to ack cycle:
  - Write: 2 cycles.
  - Read: 2 + RD_LAT cycles (3 at default).
- Starvation counter wait_cnt, 4 bits, saturating at MAX_WAIT:
  - Increments on each PPU grant while ld_req = 1.
  - Clears on a loader grant or whenever ld_req = 0.
- chr_ready:
  - Sets at the ACK of a loader write with ld_last = 1.
  - Cleared only by rst.
- Loader reads and writes are allowed regardless of chr_ready.
- Non-winning requests are untouched: req stays pending and no ack is issued.
- Address, we and data are sampled only in IDLE. Changes to them while req is held after a grant are ignored.

Optional Feature:
- Macro: CHR_LOCK_EN.
- Defined: once chr_ready = 1, loader writes are acked on the normal schedule but mem_we stays 0 (CHR ROM write-protect); loader reads are unaffected.
- Undefined: loader writes always reach memory, including after chr_ready.

Test Plan:
- Reset, then ppu_req addr 0x0010 with chr_ready = 0 → ppu_ack 1 cycle later, ppu_rdata = 0x00, mem_we never high.
- Loader writes 0xA5 to 0x0010 with ld_last = 1 → mem_we high one cycle with mem_addr 0x0010 and mem_din 0xA5; ld_ack 2 cycles after the request; chr_ready = 1 from the ack cycle on.
- Then ppu_req addr 0x0010 → ppu_ack 3 cycles after the request (RD_LAT = 1), ppu_rdata = 0xA5; ld_req with ld_we = 0 at 0x0010 → ld_rdata = 0xA5.
- ppu_req held continuously (re-requesting after each ack) with ld_req asserted → exactly MAX_WAIT = 4 PPU acks, then 1 ld_ack, then PPU resumes.
- ppu_req and ld_req rise in the same cycle with wait_cnt = 0 → PPU granted first; loader acked on the following transaction.
- rst asserted during WAIT → no ack; all outputs are 0 the cycle after rst; chr_ready = 0. With CHR_LOCK_EN defined, a post-ready loader write of 0x3C → ld_ack issued, memory unchanged on read-back.

Source files
------------

// File: rtl/chr_mem_if.sv
// Bus bundle between the CHR RAM arbiter, its two requesters and the block RAM.
// Handshake: req is a level held with stable addr/we/data until the one-cycle ack; the
// requester drops or changes req at the clock edge that ends the ack cycle. Read data is
// valid with ack (ppu_rdata also holds until the next PPU ack).
interface chr_mem_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_ack;
  logic [DATA_W-1:0] ppu_rdata;

  logic              ld_req;
  logic              ld_we;
  logic              ld_last;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              chr_ready;
  logic [1:0]        dbg_state;

  modport slave (
    input  ppu_req, ppu_addr, ld_req, ld_we, ld_last, ld_addr, ld_wdata, mem_dout,
    output ppu_ack, ppu_rdata, ld_ack, ld_rdata, mem_addr, mem_we, mem_din,
           chr_ready, dbg_state
  );

  modport master (
    output ppu_req, ppu_addr, ld_req, ld_we, ld_last, ld_addr, ld_wdata, mem_dout,
    input  ppu_ack, ppu_rdata, ld_ack, ld_rdata, mem_addr, mem_we, mem_din,
           chr_ready, dbg_state
  );
endinterface

// File: rtl/chr_mem_arbiter.sv
// Arbitrates the single-port CHR block RAM between the PPU fetch bridge and the SDRAM loader.
// Optional macro CHR_LOCK_EN: write-protect CHR RAM against loader writes once chr_ready is set.
module chr_mem_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input logic clk,
    input logic rst,
    chr_mem_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [1:0] LAT_LAST   = 2'(RD_LAT - 1);

    logic [1:0] state;
    logic       win_ld;
    logic       we_q;
    logic       last_q;
    logic [3:0] wait_cnt;
    logic [1:0] lat_cnt;

    logic starved;
    logic grant_ld;
    logic grant_ppu;
    logic ld_wr_en;

    // The starvation guard only overrides the PPU when the loader has been passed over MAX_WAIT times.
    always_comb begin
        starved   = 1'b0;
        grant_ld  = 1'b0;
        grant_ppu = 1'b0;
        starved   = bus.ld_req && (wait_cnt == MAX_WAIT_C);
        grant_ld  = bus.ld_req && (starved || !bus.ppu_req);
        grant_ppu = bus.ppu_req && !grant_ld;
    end

`ifdef CHR_LOCK_EN
    assign ld_wr_en = !bus.chr_ready;
`else
    assign ld_wr_en = 1'b1;
`endif

    assign bus.ppu_ack   = (state == S_ACK) && !win_ld;
    assign bus.ld_ack    = (state == S_ACK) && win_ld;
    assign bus.dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            win_ld        <= 1'b0;
            we_q          <= 1'b0;
            last_q        <= 1'b0;
            wait_cnt      <= 4'd0;
            lat_cnt       <= 2'd0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_din   <= {DATA_W{1'b0}};
            bus.mem_we    <= 1'b0;
            bus.ppu_rdata <= {DATA_W{1'b0}};
            bus.ld_rdata  <= {DATA_W{1'b0}};
            bus.chr_ready <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            if (!bus.ld_req) wait_cnt <= 4'd0;

            case (state)
                S_IDLE: begin
                    if (grant_ld) begin
                        win_ld       <= 1'b1;
                        we_q         <= bus.ld_we;
                        last_q       <= bus.ld_last;
                        bus.mem_addr <= bus.ld_addr;
                        bus.mem_din  <= bus.ld_wdata;
                        bus.mem_we   <= bus.ld_we && ld_wr_en;
                        wait_cnt     <= 4'd0;
                        state        <= S_ISSUE;
                    end else if (grant_ppu) begin
                        win_ld <= 1'b0;
                        we_q   <= 1'b0;
                        last_q <= 1'b0;
                        if (bus.ld_req && (wait_cnt != MAX_WAIT_C)) wait_cnt <= wait_cnt + 4'd1;
                        // Until the loader has filled the RAM the PPU gets zeros without touching memory.
                        if (bus.chr_ready) begin
                            bus.mem_addr <= bus.ppu_addr;
                            state        <= S_ISSUE;
                        end else begin
                            bus.ppu_rdata <= {DATA_W{1'b0}};
                            state         <= S_ACK;
                        end
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        if (last_q) bus.chr_ready <= 1'b1;
                        state <= S_ACK;
                    end else begin
                        lat_cnt <= 2'd0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (win_ld) bus.ld_rdata <= bus.mem_dout;
                        else        bus.ppu_rdata <= bus.mem_dout;
                        state <= S_ACK;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chr_mem_arbiter.sv
// Directed bench for chr_mem_arbiter: vector table of single transactions plus sequences
// for arbitration order, starvation guard, reset mid-read and write-protect.
module tb_chr_mem_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

`ifdef CHR_LOCK_EN
  localparam bit LOCKED = 1'b1;
`else
  localparam bit LOCKED = 1'b0;
`endif

  logic clk;
  logic rst;
  logic ram_init;

  chr_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  chr_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_WAIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- block RAM model (RD_LAT = 1) ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      rd_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_dout = rd_q;

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ppu_ack"},   32'(bus.ppu_ack), 0);
    check({tag, "_ppu_rdata"}, 32'(bus.ppu_rdata), 0);
    check({tag, "_ld_ack"},    32'(bus.ld_ack), 0);
    check({tag, "_ld_rdata"},  32'(bus.ld_rdata), 0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr), 0);
    check({tag, "_mem_we"},    32'(bus.mem_we), 0);
    check({tag, "_mem_din"},   32'(bus.mem_din), 0);
    check({tag, "_chr_ready"}, 32'(bus.chr_ready), 0);
    check({tag, "_state"},     32'(bus.dbg_state), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.ppu_req  = 1'b0;
    bus.ppu_addr = '0;
    bus.ld_req   = 1'b0;
    bus.ld_we    = 1'b0;
    bus.ld_last  = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_wdata = '0;
  endtask

  // One isolated transaction; latency counted in clock edges from request to ack cycle.
  task automatic txn(input string nm, input logic is_ld, input logic we, input logic last,
                     input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input int exp_lat, input logic [DW-1:0] exp_rdata,
                     input int exp_we, input logic exp_ready);
    int n, we_cnt, wrong;
    logic got;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_din;
    n = 0; we_cnt = 0; wrong = 0; got = 1'b0; seen_addr = '0; seen_din = '0;
    @(negedge clk);
    if (is_ld) begin
      bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_last = last;
      bus.ld_addr = addr; bus.ld_wdata = wdata;
    end else begin
      bus.ppu_req = 1'b1; bus.ppu_addr = addr;
    end
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.mem_we) begin
        we_cnt++;
        seen_addr = bus.mem_addr;
        seen_din  = bus.mem_din;
      end
      if (is_ld ? bus.ppu_ack : bus.ld_ack) wrong++;
      if (is_ld ? bus.ld_ack : bus.ppu_ack) got = 1'b1;
    end
    check({nm, "_ack_seen"}, 32'(got), 1);
    check({nm, "_latency"}, 32'(n), 32'(exp_lat));
    check({nm, "_other_ack"}, 32'(wrong), 0);
    check({nm, "_mem_we_cycles"}, 32'(we_cnt), 32'(exp_we));
    if (exp_we == 1) begin
      check({nm, "_mem_addr"}, 32'(seen_addr), 32'(addr));
      check({nm, "_mem_din"}, 32'(seen_din), 32'(wdata));
    end
    if (!we) check({nm, "_rdata"}, 32'(is_ld ? bus.ld_rdata : bus.ppu_rdata), 32'(exp_rdata));
    check({nm, "_chr_ready"}, 32'(bus.chr_ready), 32'(exp_ready));
    idle_inputs();
  endtask

  // Runs until exp_q drains; ppu_keep re-requests the PPU after each of its acks.
  task automatic run_arb(input string nm, input logic ppu_keep, output int ld_ack_at);
    int n;
    logic [0:0] e;
    n = 0;
    ld_ack_at = -1;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check({nm, "_no_double_ack"}, 32'(bus.ppu_ack && bus.ld_ack), 0);
      if (bus.ppu_ack || bus.ld_ack) begin
        e = exp_q.pop_front();
        check({nm, "_order"}, 32'(bus.ld_ack), 32'(e));
        if (bus.ld_ack) begin
          ld_ack_at = n;
          bus.ld_req = 1'b0;
        end
        if (bus.ppu_ack && (!ppu_keep || exp_q.size() == 0)) bus.ppu_req = 1'b0;
      end
    end
    check({nm, "_queue_drained"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    idle_inputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           is_ld;
    logic           we;
    logic           last;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    int             lat;
    logic [DW-1:0]  rdata;
    int             we_cnt;
    logic           ready;
  } vec_t;

  vec_t vecs[12];
  int   ld_at;

  initial begin
    // is_ld we last addr wdata lat rdata we_cnt ready
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 13'h0010, 8'h00, 1, 8'h00, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 13'h0020, 8'h00, 3, 8'h7A, 0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 13'h0030, 8'h11, 2, 8'h00, 1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 13'h0030, 8'h00, 3, 8'h11, 0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 13'h0030, 8'h00, 1, 8'h00, 0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 13'h0010, 8'hA5, 2, 8'h00, 1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 13'h0010, 8'h00, 3, 8'hA5, 0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 13'h0010, 8'h00, 3, 8'hA5, 0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 13'h1FFE, 8'h00, 3, 8'hA4, 0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 13'h1FFF, 8'h3C, 2, 8'h00, LOCKED ? 0 : 1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 13'h1FFF, 8'h00, 3, LOCKED ? 8'hA5 : 8'h3C, 0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 13'h0000, 8'h00, 3, 8'h5A, 0, 1'b1};

    idle_inputs();
    rst = 1'b1;
    ram_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    ram_init = 1'b0;

    for (int i = 0; i < 12; i++)
      txn($sformatf("vec%0d", i), vecs[i].is_ld, vecs[i].we, vecs[i].last, vecs[i].addr,
          vecs[i].wdata, vecs[i].lat, vecs[i].rdata, vecs[i].we_cnt, vecs[i].ready);

    // Both requests rise together with wait_cnt = 0: PPU first, loader next transaction.
    @(negedge clk);
    bus.ppu_req = 1'b1; bus.ppu_addr = 13'h0000;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 13'h0010;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    run_arb("same_cycle", 1'b0, ld_at);
    check("same_cycle_ld_latency", 32'(ld_at), 7);
    check("same_cycle_ppu_rdata", 32'(bus.ppu_rdata), 32'h5A);
    check("same_cycle_ld_rdata", 32'(bus.ld_rdata), 32'hA5);

    // PPU held continuously against a pending loader: 4 PPU grants, then the loader.
    @(negedge clk);
    bus.ppu_req = 1'b1; bus.ppu_addr = 13'h0010;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 13'h0020;
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    run_arb("starve", 1'b1, ld_at);
    check("starve_ld_rdata", 32'(bus.ld_rdata), 32'h7A);

    // Reset asserted while a PPU read sits in WAIT.
    @(negedge clk);
    bus.ppu_req = 1'b1; bus.ppu_addr = 13'h0000;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_issue_state", 32'(bus.dbg_state), 1);
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_wait_state", 32'(bus.dbg_state), 2);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_wait");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst_wait_quiet%0d", i), 32'({bus.ppu_ack, bus.ld_ack, bus.mem_we}), 0);
    end

    // After reset chr_ready is clear again, then refill and probe the write-protect.
    txn("post_rst_ppu", 1'b0, 1'b0, 1'b0, 13'h0010, 8'h00, 1, 8'h00, 0, 1'b0);
    txn("refill", 1'b1, 1'b1, 1'b1, 13'h0040, 8'h77, 2, 8'h00, 1, 1'b1);
    txn("post_ready_wr", 1'b1, 1'b1, 1'b0, 13'h0040, 8'h3C, 2, 8'h00, LOCKED ? 0 : 1, 1'b1);
    txn("post_ready_rd", 1'b1, 1'b0, 1'b0, 13'h0040, 8'h00, 3, LOCKED ? 8'h77 : 8'h3C, 0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
